// File: rtl/asteroid_pkg.sv
// Shared constants and types for the asteroid object manager.
package asteroid_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned SPRITE_SIZE = 38;
  localparam int unsigned X_SCALE     = 18;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    SPAWN
  } state_t;

  // Horizontal spawn position from the 5-bit random value (0..558).
  function automatic logic [COORD_W-1:0] spawn_x(input logic [4:0] r);
    return COORD_W'(r) * COORD_W'(X_SCALE);
  endfunction

endpackage

// File: rtl/asteroid_field_if.sv
// Scan-position inputs, game controls and per-slot object outputs.
interface asteroid_field_if #(
  parameter int unsigned NUM_SLOTS = 3
);
  import asteroid_pkg::*;

  logic [COORD_W-1:0]           vaddress;
  logic [COORD_W-1:0]           haddress;
  logic                         halt;
  logic                         restart;
  logic [4:0]                   random;
  logic [NUM_SLOTS-1:0]         obj_valid;
  logic [COORD_W*NUM_SLOTS-1:0] obj_x;
  logic [COORD_W*NUM_SLOTS-1:0] obj_y;
  logic                         frame_tick;
  logic                         dodged;

  modport master (
    output vaddress, haddress, halt, restart, random,
    input  obj_valid, obj_x, obj_y, frame_tick, dodged
  );

  modport slave (
    input  vaddress, haddress, halt, restart, random,
    output obj_valid, obj_x, obj_y, frame_tick, dodged
  );

endinterface

// File: rtl/asteroid_field_spawn_timer.sv
// Saturating frame counter between spawns; holds at expiry until a spawn is taken.
module spawn_timer #(
  parameter int unsigned SPAWN_GAP = 45
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic step,
  input  logic take,
  output logic spawn_due
);

  localparam int unsigned CNT_W = $clog2(SPAWN_GAP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPAWN_GAP - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign spawn_due = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (step) begin
      if (take) begin
        cnt_d = '0;
      end else if (!spawn_due) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/asteroid_field.sv
// Asteroid slot pool: per-frame fall/retire pass and timed spawning in vertical blanking.
module asteroid_field
  import asteroid_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 3,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned SPAWN_GAP = 45,
  parameter int unsigned FALL_STEP = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  asteroid_field_if.slave  bus
);

  localparam int unsigned KW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned SUM_W = COORD_W + 1;

  state_t                             state_q, state_d;
  logic [KW-1:0]                      k_q, k_d;
  logic [NUM_SLOTS-1:0]               valid_q, valid_d;
  logic [NUM_SLOTS-1:0][COORD_W-1:0]  x_q, x_d;
  logic [NUM_SLOTS-1:0][COORD_W-1:0]  y_q, y_d;
  logic                               frame_tick_q, frame_tick_d;
  logic                               dodged_q, dodged_d;

  logic [SUM_W-1:0] fall_sum;
  logic             free_found;
  logic [KW-1:0]    free_idx;
  logic             spawn_step, spawn_take, spawn_due;

  spawn_timer #(
    .SPAWN_GAP(SPAWN_GAP)
  ) u_spawn_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (bus.restart),
    .step     (spawn_step),
    .take     (spawn_take),
    .spawn_due(spawn_due)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    valid_d      = valid_q;
    x_d          = x_q;
    y_d          = y_q;
    dodged_d     = 1'b0;
    frame_tick_d = (bus.vaddress == COORD_W'(V_ACTIVE)) && (bus.haddress == '0);
    fall_sum     = {1'b0, y_q[k_q]} + SUM_W'(FALL_STEP);
    spawn_step   = 1'b0;
    spawn_take   = 1'b0;

    // Descending scan so the lowest free index wins.
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
      if (!valid_q[KW'(i - 1)]) begin
        free_found = 1'b1;
        free_idx   = KW'(i - 1);
      end
    end

    case (state_q)
      IDLE: begin
        if (frame_tick_q && !bus.halt) begin
          state_d = UPDATE;
          k_d     = '0;
        end
      end
      UPDATE: begin
        if (valid_q[k_q]) begin
          if (fall_sum >= SUM_W'(V_ACTIVE)) begin
            valid_d[k_q] = 1'b0;
            dodged_d     = 1'b1;
          end else begin
            y_d[k_q] = fall_sum[COORD_W-1:0];
          end
        end
        if (k_q == KW'(NUM_SLOTS - 1)) begin
          state_d = SPAWN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      SPAWN: begin
        spawn_step = 1'b1;
        if (spawn_due && free_found) begin
          spawn_take         = 1'b1;
          valid_d[free_idx]  = 1'b1;
          y_d[free_idx]      = '0;
          x_d[free_idx]      = spawn_x(bus.random);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.restart) begin
      state_d  = IDLE;
      k_d      = '0;
      valid_d  = '0;
      x_d      = '0;
      y_d      = '0;
      dodged_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      valid_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      frame_tick_q <= 1'b0;
      dodged_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      valid_q      <= valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_tick_q <= frame_tick_d;
      dodged_q     <= dodged_d;
    end
  end

  assign bus.obj_valid  = valid_q;
  assign bus.obj_x      = x_q;
  assign bus.obj_y      = y_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.dodged     = dodged_q;

endmodule
